// File: rtl/booth_seq_mul_pkg.sv
// Shared definitions for the sequential Booth multiplier and the ALU it borrows as its adder.
package booth_seq_mul_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/booth_seq_mul_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface booth_seq_mul_if;
  import booth_seq_mul_pkg::*;

  logic              start_i;
  logic [WIDTH-1:0]  src1_i;
  logic [WIDTH-1:0]  src2_i;
  logic              busy_o;
  logic              done_o;
  logic [PROD_W-1:0] result_o;

  modport master (output start_i, src1_i, src2_i, input busy_o, done_o, result_o);
  modport slave  (input start_i, src1_i, src2_i, output busy_o, done_o, result_o);
endinterface

// File: rtl/booth_seq_mul_alu.sv
// The existing 32-bit ALU; invert_b also supplies the carry-in so a - b is a + ~b + 1.
module booth_seq_mul_alu
  import booth_seq_mul_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_a,
  input  logic             invert_b,
  input  alu_op_e          operation,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  always_comb begin
    a_eff    = invert_a ? ~a : a;
    b_eff    = invert_b ? ~b : b;
    sum      = a_eff + b_eff + WIDTH'(invert_b);
    overflow = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
    case (operation)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      OP_SLT:  result = WIDTH'(sum[WIDTH-1] ^ overflow);
      default: result = sum;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Signed 32x32->64 radix-2 Booth multiplier, one step per clock, using the shared ALU as adder.
module booth_seq_mul
  import booth_seq_mul_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  booth_seq_mul_if.slave  bus
);

  state_e           state_q, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] q_q, q_nxt;
  logic [WIDTH-1:0] m_q, m_nxt;
  logic             qm1_q, qm1_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             busy_q, done_q;

  logic             use_alu;
  logic             alu_inv_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_zero_unused;
  logic [WIDTH-1:0] a_step;
  logic             sign_bit;

  booth_seq_mul_alu u_alu (
    .a         (a_q),
    .b         (m_q),
    .invert_a  (1'b0),
    .invert_b  (alu_inv_b),
    .operation (OP_ADD),
    .result    (alu_res),
    .overflow  (alu_ovf),
    .zero      (alu_zero_unused)
  );

  // Booth recoding; the sign fix-up keeps the 33-bit intermediate correct after the shift
  always_comb begin
    use_alu   = 1'b0;
    alu_inv_b = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01:   use_alu = 1'b1;
      2'b10: begin
        use_alu   = 1'b1;
        alu_inv_b = 1'b1;
      end
      default: use_alu = 1'b0;
    endcase
    a_step   = use_alu ? alu_res : a_q;
    sign_bit = use_alu ? (alu_res[WIDTH-1] ^ alu_ovf) : a_q[WIDTH-1];
  end

  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    q_nxt     = q_q;
    m_nxt     = m_q;
    qm1_nxt   = qm1_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          m_nxt     = bus.src1_i;
          q_nxt     = bus.src2_i;
          a_nxt     = '0;
          qm1_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_nxt   = {sign_bit, a_step[WIDTH-1:1]};
        q_nxt   = {a_step[0], q_q[WIDTH-1:1]};
        qm1_nxt = q_q[0];
        cnt_nxt = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      q_q     <= q_nxt;
      m_q     <= m_nxt;
      qm1_q   <= qm1_nxt;
      cnt_q   <= cnt_nxt;
      busy_q  <= (state_nxt == ST_RUN);
      done_q  <= (state_nxt == ST_DONE);
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = {a_q, q_q};

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: directed products, start/reset corner cases and random signed pairs.
module tb_booth_seq_mul;
  import booth_seq_mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mul_if bus ();

  booth_seq_mul dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Transaction-level model: an accepted start yields 32 busy cycles, then a done pulse with the product
  int          m_left  = 0;
  logic        m_done  = 1'b0;
  logic [63:0] m_prod  = '0;
  bit          m_valid = 1'b0;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    return 64'(sx * sy);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_left = 0; m_done = 1'b0; m_prod = '0; m_valid = 1'b1;
    end else if (m_left == 0 && bus.start_i) begin
      m_left = 32; m_done = 1'b0; m_valid = 1'b0;
      m_prod = ref_mul(bus.src1_i, bus.src2_i);
    end else if (m_left > 0) begin
      m_left--;
      m_done  = (m_left == 0);
      m_valid = (m_left == 0);
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy_o), 64'(m_left > 0));
      check("done", 64'(bus.done_o), 64'(m_done));
      if (m_valid) check("result", bus.result_o, m_prod);
    end
  end

  task automatic wait_done(input int lat0, output int lat, output bit ok);
    lat = lat0;
    while (!bus.done_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ok = bus.done_o;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: done_o not seen within %0d cycles at %0t", lat, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge where done_o is high
  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp,
                     input string name);
    int lat;
    bit ok;
    bus.start_i = 1'b1;
    bus.src1_i  = x;
    bus.src2_i  = y;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    wait_done(1, lat, ok);
    if (ok) begin
      check({name, "_lat"}, 64'(lat), 64'd33);
      check(name, bus.result_o, exp);
    end
  endtask

  initial begin
    int lat;
    bit ok;
    logic [31:0] x, y;
    bus.start_i = 1'b0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    rst = 1'b1;

    run(32'd3, 32'd5, 64'h0000_0000_0000_000F, "p3x5");
    @(negedge clk);
    check("idle_busy", 64'(bus.busy_o), 64'd0);
    check("hold_result", bus.result_o, 64'h0000_0000_0000_000F);
    run(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, "m7x6");
    @(negedge clk);
    run(32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, "6xm7");
    @(negedge clk);
    run(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_sq");
    @(negedge clk);
    run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_sq");
    @(negedge clk);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1_sq");
    @(negedge clk);

    // Start while busy is ignored; start in DONE is accepted with no idle gap
    bus.start_i = 1'b1; bus.src1_i = 32'd2; bus.src2_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.start_i = 1'b1; bus.src1_i = 32'd9; bus.src2_i = 32'd9;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(11, lat, ok);
    if (ok) begin
      check("ign_lat", 64'(lat), 64'd33);
      check("ign_result", bus.result_o, 64'd6);
    end
    run(32'd4, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, "b2b_4xm1");
    @(negedge clk);

    // Reset in the middle of a run
    bus.start_i = 1'b1; bus.src1_i = 32'd7; bus.src2_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_done", 64'(bus.done_o), 64'd0);
    check("mid_rst_result", bus.result_o, 64'd0);
    rst = 1'b1;
    run(32'd10, 32'd10, 64'd100, "p10x10");
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      run(x, y, ref_mul(x, y), "rand");
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
- Multi-cycle signed 32x32 -> 64-bit multiplier. Radix-2 Booth algorithm, one Booth step per clock.
- Sits directly upstream of the 32-bit ALU and drives it as its add/subtract engine:
  - feeds the ALU operands and invertB/operation;
  - consumes the ALU result and overflow each cycle.
- Gives the execute stage mul support without a second adder.

Parameters:
- WIDTH, 32, operand width. Fixed to the ALU width; no other value supported.
- CNT_W, 6, iteration counter width (holds 0..WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  request. Accepted only in IDLE or DONE.
- src1_i  in  32  multiplicand, two's complement.
- src2_i  in  32  multiplier, two's complement.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse when product is valid.
- result_o  out  64  signed product. Held until the next accepted start.

Behaviour:
- Reset (rst_i=0 at a clock edge), including mid-operation:
  - state=IDLE; A, Q, M, q_m1 and count cleared;
  - busy_o=0, done_o=0, result_o=0.
- Registers:
  - M[31:0] multiplicand;
  - A[31:0] accumulator;
  - Q[31:0] multiplier/low product;
  - q_m1 Booth guard bit;
  - count[CNT_W-1:0].
- States: IDLE, RUN, DONE.
  - IDLE: start_i=1 -> M=src1_i, Q=src2_i, A=0, q_m1=0, count=0, go RUN. Otherwise stay.
  - RUN: one Booth step per cycle (below); count++. When count reaches WIDTH-1 on the current step, go DONE.
  - DONE: done_o=1 for exactly this cycle.
    - start_i=1 -> reload as from IDLE, go RUN.
    - else go IDLE.
- Booth step on {Q[0], q_m1}:
  - 01: A' = A + M. ALU invertA=0, invertB=0, operation=OP_ADD.
  - 10: A' = A - M. ALU invertB=1 (carry-in=1), operation=OP_ADD.
  - 00/11: A' = A. ALU result is not used.
- Arithmetic shift right of {A', Q, q_m1} by one:
  - new A[31] = true sign bit;
  - new q_m1 = Q[0].
- True sign bit:
  - add/sub steps: ALU result[31] XOR ALU overflow;
  - no-op steps: A[31].
  - This correction is mandatory; it makes M=0x80000000 correct.
- ALU zero output is unused.
- ALU inputs are driven combinationally from A and M. ALU output is consumed in the same cycle, a single-cycle path.
- Latency: start accepted at edge N -> done_o high in the cycle after edge N+32. That is 32 RUN cycles, then DONE.
- Throughput: one product per 33 cycles with back-to-back start in DONE.
- Output timing:
  - busy_o=1 exactly in RUN.
  - start_i while busy is ignored. No queuing; operands are not re-sampled.
- result_o = {A,Q}. Meaningful when done_o=1 and thereafter until the next accepted start. Its value during RUN is unspecified.
- src1_i/src2_i are sampled only at accept. Changes later have no effect.
- Unsigned multiply is out of scope. Caller uses signed operands only.

Decomposition:
- Shared package holds:
  - ALU operation encodings (OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SLT=2'b11);
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - WIDTH.
- One sub-module: the existing 32-bit ALU, instantiated once as the adder/subtractor.
- The FSM, shift register and counter are in booth_seq_mul itself.

Test Plan:
- src1=3, src2=5, start pulse -> busy 32 cycles, done pulse in cycle 33, result_o=0x000000000000000F.
- src1=0xFFFFFFF9 (-7), src2=6 -> result_o=0xFFFFFFFFFFFFFFD6 (-42). Also check swapped operands give the same result.
- Extremes (exercises the overflow sign correction):
  - 0x80000000 x 0x80000000 -> 0x4000000000000000;
  - 0x7FFFFFFF x 0x7FFFFFFF -> 0x3FFFFFFF00000001;
  - 0xFFFFFFFF x 0xFFFFFFFF -> 0x0000000000000001.
- Start 2+3 accepted; start_i re-asserted with src 9, 9 at cycle 10 of RUN -> ignored, result_o=6. Then start asserted during the DONE cycle with 4 x -1 -> accepted, next result_o=0xFFFFFFFFFFFFFFFC, no idle gap.
- rst_i=0 at RUN cycle 15 -> next cycle busy_o=0, done_o=0, result_o=0, IDLE. New start 10 x 10 completes normally with 100.
- Random signed pairs (1000 runs) against a 64-bit reference product. Check done_o is exactly one cycle wide and busy_o=0 in IDLE and DONE.
